stopwatch_ctrl_fsm: RTL and testbench

//  Sequencer for the stopwatch datapath. Turns three raw push buttons (start/stop, lap, clear)

---
 rtl/stopwatch_ctrl_fsm.sv | 131 +++++++++++++
 tb/tb_stopwatch_ctrl_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch control sequencer: synchronises, debounces and edge-detects three
// push buttons, then runs the run/lap/clear FSM that builds the core's control word.
module stopwatch_ctrl_fsm #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CLR_CYCLES      = 4
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       btn_start,
  input  logic       btn_lap,
  input  logic       btn_clear,
  output logic [3:0] sw_control_reg,
  output logic [2:0] state,
  output logic [7:0] lap_cnt,
  output logic       running
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int TW = $clog2(CLR_CYCLES + 1);

  typedef enum logic [2:0] {
    S_CLR       = 3'd0,
    S_IDLE      = 3'd1,
    S_RUN       = 3'd2,
    S_PAUSE     = 3'd3,
    S_RUN_LAP   = 3'd4,
    S_PAUSE_LAP = 3'd5
  } state_t;

  // Button vectors are ordered {clear, lap, start}.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1, sync2, deb, deb_q, ev;
  logic [CW-1:0] cnt [3];

  assign btn_raw = {btn_clear, btn_lap, btn_start};

  // NOTE: every flop here, including the per-button counter array, is cleared
  // by reset so a mid-operation reset discards partial debounce progress.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      ev    <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage read the previous
      // cycle's value, which is what gives the fixed pipeline latency.
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_q <= deb;
      ev    <= deb & ~deb_q;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t        state_q, nxt;
  logic [TW-1:0] timer;

  // Active states are a run bit and a lap bit; start toggles run, lap toggles lap.
  function automatic state_t step(input state_t s, input logic [TW-1:0] t,
                                  input logic e_start, input logic e_lap,
                                  input logic e_clear);
    logic run_b, lap_b;
    run_b = 1'b0;
    lap_b = 1'b0;
    step  = S_CLR;
    case (s)
      S_CLR:  step = (!e_clear && t == TW'(1)) ? S_IDLE : S_CLR;
      S_IDLE: step = e_clear ? S_CLR : (e_start ? S_RUN : S_IDLE);
      S_RUN, S_PAUSE, S_RUN_LAP, S_PAUSE_LAP: begin
        if (e_clear) begin
          step = S_CLR;
        end else begin
          run_b = ((s == S_RUN) || (s == S_RUN_LAP)) ^ e_start;
          lap_b = ((s == S_RUN_LAP) || (s == S_PAUSE_LAP)) ^ e_lap;
          step  = run_b ? (lap_b ? S_RUN_LAP : S_RUN)
                        : (lap_b ? S_PAUSE_LAP : S_PAUSE);
        end
      end
      default: step = S_CLR;
    endcase
  endfunction

  function automatic logic [3:0] ctrl_word(input state_t s);
    case (s)
      S_CLR:       ctrl_word = 4'b0100;
      S_RUN:       ctrl_word = 4'b0001;
      S_RUN_LAP:   ctrl_word = 4'b0011;
      S_PAUSE_LAP: ctrl_word = 4'b0010;
      default:     ctrl_word = 4'b0000;
    endcase
  endfunction

  assign nxt = step(state_q, timer, ev[0], ev[1], ev[2]);

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q        <= S_CLR;
      timer          <= TW'(CLR_CYCLES);
      sw_control_reg <= 4'b0100;
      lap_cnt        <= '0;
    end else begin
      state_q        <= nxt;
      sw_control_reg <= ctrl_word(nxt);
      if (nxt == S_CLR) begin
        // Fresh entry or a repeated clear restarts the hold period.
        if (state_q == S_CLR && !ev[2]) timer <= timer - 1'b1;
        else                            timer <= TW'(CLR_CYCLES);
        lap_cnt <= '0;
      end else if ((nxt == S_RUN_LAP || nxt == S_PAUSE_LAP) && nxt != state_q
                   && lap_cnt != 8'hFF) begin
        lap_cnt <= lap_cnt + 8'd1;
      end
    end
  end

  assign state   = state_q;
  assign running = sw_control_reg[0];

endmodule

// File: tb/tb_stopwatch_ctrl_fsm.sv
// Self-checking bench for stopwatch_ctrl_fsm: directed timing scenarios plus
// randomized button presses checked against a press-level behavioural model.
module tb_stopwatch_ctrl_fsm;

  localparam int DEB = 4;
  localparam int CLR = 3;

  logic       clk = 1'b0;
  logic       reset_p = 1'b1;
  logic       btn_start = 1'b0, btn_lap = 1'b0, btn_clear = 1'b0;
  logic [3:0] sw_control_reg;
  logic [2:0] state;
  logic [7:0] lap_cnt;
  logic       running;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl_fsm #(.DEBOUNCE_CYCLES(DEB), .CLR_CYCLES(CLR)) dut (
    .clk(clk), .reset_p(reset_p), .btn_start(btn_start), .btn_lap(btn_lap),
    .btn_clear(btn_clear), .sw_control_reg(sw_control_reg), .state(state),
    .lap_cnt(lap_cnt), .running(running)
  );

  // Model: observed after each press has fully settled (any clear hold elapsed).
  bit m_active;   // 0 = idle, 1 = running or paused
  bit m_run;
  bit m_lapv;
  int m_laps;

  function automatic void model_reset();
    m_active = 0; m_run = 0; m_lapv = 0; m_laps = 0;
  endfunction

  function automatic void model_press(input bit s, input bit l, input bit c);
    bit new_lap;
    if (c) begin
      model_reset();
    end else if (!m_active) begin
      if (s) begin m_active = 1; m_run = 1; m_lapv = 0; end
    end else if (s || l) begin
      m_run   = m_run ^ s;
      new_lap = m_lapv ^ l;
      if (new_lap && m_laps < 255) m_laps++;
      m_lapv  = new_lap;
    end
  endfunction

  function automatic logic [2:0] exp_state();
    if (!m_active) return 3'd1;
    if (m_lapv)    return m_run ? 3'd4 : 3'd5;
    return m_run ? 3'd2 : 3'd3;
  endfunction

  function automatic logic [3:0] exp_ctrl();
    return {2'b00, m_active & m_lapv, m_active & m_run};
  endfunction

  // Drive a press at a negedge, hold, release, wait to settle; ends on a negedge.
  task automatic press(input bit s, input bit l, input bit c, input int hold, input int gap);
    btn_start = s; btn_lap = l; btn_clear = c;
    repeat (hold) @(negedge clk);
    btn_start = 0; btn_lap = 0; btn_clear = 0;
    repeat (gap) @(negedge clk);
    model_press(s, l, c);
  endtask

  task automatic test_reset();
    logic [3:0] e_sw;
    logic [2:0] e_st;
    reset_p = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (sw_control_reg !== 4'b0100) begin failures++; $display("FAIL reset_sw got=%b exp=0100", sw_control_reg); end
    checks++; if (state !== 3'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (lap_cnt !== 8'd0) begin failures++; $display("FAIL reset_lap got=%0d exp=0", lap_cnt); end
    reset_p = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      e_sw = (k < 3) ? 4'b0100 : 4'b0000;
      e_st = (k < 3) ? 3'd0 : 3'd1;
      checks++; if (sw_control_reg !== e_sw) begin failures++; $display("FAIL reset_release_sw[%0d] got=%b exp=%b", k, sw_control_reg, e_sw); end
      checks++; if (state !== e_st) begin failures++; $display("FAIL reset_release_state[%0d] got=%0d exp=%0d", k, state, e_st); end
    end
    checks++; if (lap_cnt !== 8'd0) begin failures++; $display("FAIL reset_release_lap got=%0d exp=0", lap_cnt); end
    model_reset();
  endtask

  task automatic test_debounce();
    for (int c = 0; c < 20; c++) begin
      btn_start = ((c / 2) % 2 == 0);
      @(negedge clk);
      checks++; if (sw_control_reg !== 4'b0000 || state !== 3'd1) begin
        failures++; $display("FAIL bounce[%0d] got sw=%b st=%0d exp sw=0000 st=1", c, sw_control_reg, state);
      end
    end
    btn_start = 1'b0;
    repeat (5) @(negedge clk);
    btn_start = 1'b1;            // first sampled high at edge N
    repeat (7) @(negedge clk);   // edges N..N+6
    checks++; if (state !== 3'd1 || sw_control_reg !== 4'b0000) begin
      failures++; $display("FAIL press_early got sw=%b st=%0d exp sw=0000 st=1", sw_control_reg, state);
    end
    @(negedge clk);              // edge N+7
    checks++; if (state !== 3'd2 || sw_control_reg !== 4'b0001) begin
      failures++; $display("FAIL press_latency got sw=%b st=%0d exp sw=0001 st=2", sw_control_reg, state);
    end
    btn_start = 1'b0;
    repeat (12) @(negedge clk);
    model_press(1, 0, 0);
    checks++; if (state !== exp_state() || sw_control_reg !== exp_ctrl()) begin
      failures++; $display("FAIL release_no_event got sw=%b st=%0d exp sw=%b st=%0d", sw_control_reg, state, exp_ctrl(), exp_state());
    end
  endtask

  task automatic test_lap_sequence();
    bit         ops_lap [4] = '{1, 1, 0, 1};
    logic [3:0] tbl_sw  [4] = '{4'b0011, 4'b0001, 4'b0000, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      press(!ops_lap[i], ops_lap[i], 0, 8, 10);
      checks++; if (sw_control_reg !== tbl_sw[i]) begin failures++; $display("FAIL lap_seq_sw[%0d] got=%b exp=%b", i, sw_control_reg, tbl_sw[i]); end
      checks++; if (state !== exp_state()) begin failures++; $display("FAIL lap_seq_state[%0d] got=%0d exp=%0d", i, state, exp_state()); end
      checks++; if (lap_cnt !== 8'(m_laps)) begin failures++; $display("FAIL lap_seq_cnt[%0d] got=%0d exp=%0d", i, lap_cnt, m_laps); end
    end
  endtask

  task automatic test_clear_priority();
    press(0, 1, 0, 8, 10);
    press(1, 0, 0, 8, 10);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL clr_setup_state got=%0d exp=2", state); end
    btn_start = 1'b1; btn_clear = 1'b1;
    repeat (7) @(negedge clk);
    checks++; if (state !== 3'd2) begin failures++; $display("FAIL clr_early got=%0d exp=2", state); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (sw_control_reg !== 4'b0100 || state !== 3'd0 || lap_cnt !== 8'd0) begin
        failures++; $display("FAIL clr_hold[%0d] got sw=%b st=%0d lap=%0d exp sw=0100 st=0 lap=0", k, sw_control_reg, state, lap_cnt);
      end
    end
    @(negedge clk);
    checks++; if (sw_control_reg !== 4'b0000 || state !== 3'd1 || lap_cnt !== 8'd0) begin
      failures++; $display("FAIL clr_done got sw=%b st=%0d lap=%0d exp sw=0000 st=1 lap=0", sw_control_reg, state, lap_cnt);
    end
    repeat (10) @(negedge clk);
    checks++; if (state !== 3'd1) begin failures++; $display("FAIL clr_held_start got=%0d exp=1", state); end
    btn_start = 1'b0; btn_clear = 1'b0;
    repeat (10) @(negedge clk);
    model_press(1, 0, 1);
    checks++; if (state !== exp_state() || sw_control_reg !== exp_ctrl()) begin
      failures++; $display("FAIL clr_release got sw=%b st=%0d exp sw=%b st=%0d", sw_control_reg, state, exp_ctrl(), exp_state());
    end
  endtask

  task automatic test_simul_saturation();
    int entries;
    press(1, 0, 0, 8, 10);
    press(1, 1, 0, 8, 10);
    checks++; if (state !== 3'd5 || sw_control_reg !== 4'b0010) begin
      failures++; $display("FAIL simul got sw=%b st=%0d exp sw=0010 st=5", sw_control_reg, state);
    end
    checks++; if (lap_cnt !== 8'(m_laps)) begin failures++; $display("FAIL simul_lap got=%0d exp=%0d", lap_cnt, m_laps); end
    entries = 0;
    while (entries < 300) begin
      press(0, 1, 0, 6, 9);
      if (m_lapv) entries++;
      checks++; if (state !== exp_state() || lap_cnt !== 8'(m_laps)) begin
        failures++; $display("FAIL sat_step[%0d] got st=%0d lap=%0d exp st=%0d lap=%0d", entries, state, lap_cnt, exp_state(), m_laps);
      end
    end
    checks++; if (lap_cnt !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", lap_cnt); end
  endtask

  task automatic test_random();
    bit s, l, c;
    for (int i = 0; i < 40; i++) begin
      c = ($urandom_range(0, 9) == 0);
      s = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      if (!s && !l && !c) s = 1;
      press(s, l, c, $urandom_range(6, 12), $urandom_range(9, 14));
      checks++; if (sw_control_reg !== exp_ctrl()) begin failures++; $display("FAIL rand_sw[%0d] s%0d l%0d c%0d got=%b exp=%b", i, s, l, c, sw_control_reg, exp_ctrl()); end
      checks++; if (state !== exp_state()) begin failures++; $display("FAIL rand_state[%0d] got=%0d exp=%0d", i, state, exp_state()); end
      checks++; if (lap_cnt !== 8'(m_laps)) begin failures++; $display("FAIL rand_lap[%0d] got=%0d exp=%0d", i, lap_cnt, m_laps); end
      checks++; if (running !== (m_active & m_run)) begin failures++; $display("FAIL rand_running[%0d] got=%b exp=%b", i, running, m_active & m_run); end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [2:0] e_st;
    press(0, 0, 1, 8, 10);
    press(1, 0, 0, 8, 10);
    press(0, 1, 0, 8, 10);
    checks++; if (state !== 3'd4) begin failures++; $display("FAIL rst_setup got=%0d exp=4", state); end
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    reset_p = 1'b1;
    @(negedge clk);
    reset_p = 1'b0;
    checks++; if (sw_control_reg !== 4'b0100 || state !== 3'd0 || lap_cnt !== 8'd0) begin
      failures++; $display("FAIL rst_mid got sw=%b st=%0d lap=%0d exp sw=0100 st=0 lap=0", sw_control_reg, state, lap_cnt);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e_st = (k <= 2) ? 3'd0 : ((k <= 7) ? 3'd1 : 3'd2);
      checks++; if (state !== e_st) begin failures++; $display("FAIL rst_held[%0d] got=%0d exp=%0d", k, state, e_st); end
    end
    btn_start = 1'b0;
    repeat (12) @(negedge clk);
    model_reset();
    model_press(1, 0, 0);
    checks++; if (state !== exp_state() || sw_control_reg !== exp_ctrl() || lap_cnt !== 8'(m_laps)) begin
      failures++; $display("FAIL rst_after got sw=%b st=%0d lap=%0d exp sw=%b st=%0d lap=%0d", sw_control_reg, state, lap_cnt, exp_ctrl(), exp_state(), m_laps);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_debounce();
    test_lap_sequence();
    test_clear_priority();
    test_simul_saturation();
    test_random();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
